// File: rtl/reg_file_wb.sv
// Register file with ALU write-back. Accepted results go through one pending
// stage and then commit. Reads bypass from that stage, and a busy scoreboard tracks reserved registers.
module reg_file_wb #(
  parameter  int unsigned NUM_REGS = 16,
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned FLAGS_W  = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                master_clk,
  input  logic                reset_n,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [IDX_W-1:0]    wb_dest,
  input  logic                wb_pair,
  input  logic                wb_write_data,
  input  logic                wb_write_flags,
  input  logic [DATA_W-1:0]   alu_out_lo,
  input  logic [DATA_W-1:0]   alu_out_hi,
  input  logic [FLAGS_W-1:0]  alu_proc_flags_out,
  input  logic                hold,
  input  logic                rsv_valid,
  input  logic [IDX_W-1:0]    rsv_idx,
  input  logic [IDX_W-1:0]    rd_a_sel,
  input  logic [IDX_W-1:0]    rd_b_sel,
  output logic [DATA_W-1:0]   rd_a_lo,
  output logic [DATA_W-1:0]   rd_a_hi,
  output logic [DATA_W-1:0]   rd_b,
  output logic [FLAGS_W-1:0]  proc_flags,
  output logic [NUM_REGS-1:0] busy,
  output logic                pair_err
);

  typedef struct packed {
    logic               valid;
    logic [IDX_W-1:0]   dest;
    logic               pair;
    logic               wdata;
    logic               wflags;
    logic [DATA_W-1:0]  lo;
    logic [DATA_W-1:0]  hi;
    logic [FLAGS_W-1:0] flags;
  } pend_t;

  pend_t               pend_q, pend_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [FLAGS_W-1:0]  flags_q, flags_d;
  logic [NUM_REGS-1:0] busy_q, busy_d, busy_clr, busy_set;
  logic                pair_err_q, pair_err_d;

  logic                accept;
  logic                pair_illegal;
  logic [IDX_W-1:0]    wb_hi_idx;
  logic [IDX_W-1:0]    pend_hi_idx;
  logic [IDX_W-1:0]    rd_a_hi_sel;

  assign wb_ready     = !hold;
  assign accept       = wb_valid && !hold;
  assign pair_illegal = wb_pair && wb_dest[0];
  assign wb_hi_idx    = {wb_dest[IDX_W-1:1], 1'b1};
  assign pend_hi_idx  = {pend_q.dest[IDX_W-1:1], 1'b1};

  // Capture an accepted, legal result into the pending stage.
  always_comb begin
    pend_d = '0;
    if (accept && !pair_illegal) begin
      pend_d.valid  = 1'b1;
      pend_d.dest   = wb_dest;
      pend_d.pair   = wb_pair;
      pend_d.wdata  = wb_write_data;
      pend_d.wflags = wb_write_flags;
      pend_d.lo     = alu_out_lo;
      pend_d.hi     = alu_out_hi;
      pend_d.flags  = alu_proc_flags_out;
    end
  end

  // Next-state array doubles as the bypassed read view.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_d[i] = regs_q[i];
    end
    if (pend_q.valid && pend_q.wdata) begin
      regs_d[pend_q.dest] = pend_q.lo;
      if (pend_q.pair) begin
        regs_d[pend_hi_idx] = pend_q.hi;
      end
    end
  end

  assign flags_d = (pend_q.valid && pend_q.wflags) ? pend_q.flags : flags_q;

  // Reservation set has priority over a same-edge write-back clear.
  always_comb begin
    busy_clr = '0;
    busy_set = '0;
    if (accept && !pair_illegal && wb_write_data) begin
      busy_clr[wb_dest] = 1'b1;
      if (wb_pair) begin
        busy_clr[wb_hi_idx] = 1'b1;
      end
    end
    if (rsv_valid) begin
      busy_set[rsv_idx] = 1'b1;
    end
    busy_d = (busy_q & ~busy_clr) | busy_set;
  end

  assign pair_err_d = pair_err_q | (accept && pair_illegal);

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      flags_q    <= '0;
      busy_q     <= '0;
      pair_err_q <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      pair_err_q <= pair_err_d;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign rd_a_hi_sel = rd_a_sel + IDX_W'(1);
  assign rd_a_lo     = regs_d[rd_a_sel];
  assign rd_a_hi     = regs_d[rd_a_hi_sel];
  assign rd_b        = regs_d[rd_b_sel];
  assign proc_flags  = flags_d;
  assign busy        = busy_q;
  assign pair_err    = pair_err_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: expectations are queued with each stimulus
// step and popped against the DUT outputs once they should be visible.
module tb_reg_file_wb;

  logic        master_clk = 1'b0;
  logic        reset_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_dest;
  logic        wb_pair;
  logic        wb_write_data;
  logic        wb_write_flags;
  logic [7:0]  alu_out_lo;
  logic [7:0]  alu_out_hi;
  logic [3:0]  alu_proc_flags_out;
  logic        hold;
  logic        rsv_valid;
  logic [3:0]  rsv_idx;
  logic [3:0]  rd_a_sel;
  logic [3:0]  rd_b_sel;
  logic [7:0]  rd_a_lo;
  logic [7:0]  rd_a_hi;
  logic [7:0]  rd_b;
  logic [3:0]  proc_flags;
  logic [15:0] busy;
  logic        pair_err;

  int n_checks = 0;
  int n_fail   = 0;

  string       tag_q[$];
  logic [15:0] exp_q[$];

  reg_file_wb dut (
    .master_clk         (master_clk),
    .reset_n            (reset_n),
    .wb_valid           (wb_valid),
    .wb_ready           (wb_ready),
    .wb_dest            (wb_dest),
    .wb_pair            (wb_pair),
    .wb_write_data      (wb_write_data),
    .wb_write_flags     (wb_write_flags),
    .alu_out_lo         (alu_out_lo),
    .alu_out_hi         (alu_out_hi),
    .alu_proc_flags_out (alu_proc_flags_out),
    .hold               (hold),
    .rsv_valid          (rsv_valid),
    .rsv_idx            (rsv_idx),
    .rd_a_sel           (rd_a_sel),
    .rd_b_sel           (rd_b_sel),
    .rd_a_lo            (rd_a_lo),
    .rd_a_hi            (rd_a_hi),
    .rd_b               (rd_b),
    .proc_flags         (proc_flags),
    .busy               (busy),
    .pair_err           (pair_err)
  );

  always #5 master_clk = ~master_clk;

  task automatic sb_push(input string tag, input logic [15:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic chk(input logic [15:0] obs);
    string       tag;
    logic [15:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed 0x%0h required an expectation", obs);
    end else begin
      tag = tag_q.pop_front();
      e   = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge master_clk);
    #1;
  endtask

  task automatic drive_wb(input logic [3:0] d, input logic p, input logic wd,
                          input logic wf, input logic [7:0] lo,
                          input logic [7:0] hi, input logic [3:0] f);
    wb_valid           = 1'b1;
    wb_dest            = d;
    wb_pair            = p;
    wb_write_data      = wd;
    wb_write_flags     = wf;
    alu_out_lo         = lo;
    alu_out_hi         = hi;
    alu_proc_flags_out = f;
  endtask

  task automatic wr(input logic [3:0] d, input logic p, input logic wd,
                    input logic wf, input logic [7:0] lo,
                    input logic [7:0] hi, input logic [3:0] f);
    drive_wb(d, p, wd, wf, lo, hi, f);
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; hold = 1'b0; wb_valid = 1'b0; wb_dest = '0; wb_pair = 1'b0;
    wb_write_data = 1'b0; wb_write_flags = 1'b0; alu_out_lo = '0; alu_out_hi = '0;
    alu_proc_flags_out = '0; rsv_valid = 1'b0; rsv_idx = '0;
    rd_a_sel = 4'd0; rd_b_sel = 4'd0;
    #2;
    sb_push("rst_rd_a_lo", 16'h0);  chk(16'(rd_a_lo));
    sb_push("rst_rd_a_hi", 16'h0);  chk(16'(rd_a_hi));
    sb_push("rst_rd_b", 16'h0);     chk(16'(rd_b));
    sb_push("rst_flags", 16'h0);    chk(16'(proc_flags));
    sb_push("rst_busy", 16'h0);     chk(busy);
    sb_push("rst_pair_err", 16'h0); chk(16'(pair_err));
    sb_push("rst_ready", 16'h1);    chk(16'(wb_ready));
    hold = 1'b1; #1;
    sb_push("rst_ready_hold", 16'h0); chk(16'(wb_ready));
    hold = 1'b0;
    #5 reset_n = 1'b1;

    // first edge after reset release accepts r2=0x55
    sb_push("first_acc_byp", 16'h55);
    sb_push("first_flags_byp", 16'h1);
    sb_push("first_acc_arr", 16'h55);
    wr(4'd2, 1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 4'h1);
    rd_b_sel = 4'd2; #1;
    chk(16'(rd_b)); chk(16'(proc_flags));
    tick(); chk(16'(rd_b));

    // odd pair destination is rejected
    sb_push("odd_pair_err", 16'h1);
    sb_push("odd_r5", 16'h0);
    sb_push("odd_r6", 16'h0);
    sb_push("odd_flags", 16'h1);
    sb_push("odd_err_sticky", 16'h1);
    sb_push("odd_flags_late", 16'h1);
    wr(4'd5, 1'b1, 1'b1, 1'b1, 8'hAA, 8'hBB, 4'hF);
    rd_b_sel = 4'd5; rd_a_sel = 4'd5; #1;
    chk(16'(pair_err)); chk(16'(rd_b)); chk(16'(rd_a_hi)); chk(16'(proc_flags));
    tick(); chk(16'(pair_err)); chk(16'(proc_flags));

    sb_push("rsv9_busy", 16'h0200);
    rsv_valid = 1'b1; rsv_idx = 4'd9;
    tick(); rsv_valid = 1'b0; #1;
    chk(busy);

    // reset mid-stream with a pending write in flight
    sb_push("pend_r2_byp", 16'h66);
    sb_push("midrst_r2", 16'h0);
    sb_push("midrst_flags", 16'h0);
    sb_push("midrst_busy", 16'h0);
    sb_push("midrst_pair_err", 16'h0);
    sb_push("midrst_ready", 16'h1);
    sb_push("postrst_r2", 16'h0);
    sb_push("postrst_flags", 16'h0);
    wr(4'd2, 1'b0, 1'b1, 1'b1, 8'h66, 8'h00, 4'h4);
    rd_b_sel = 4'd2; #1;
    chk(16'(rd_b));
    reset_n = 1'b0; #1;
    chk(16'(rd_b)); chk(16'(proc_flags)); chk(busy); chk(16'(pair_err)); chk(16'(wb_ready));
    tick(); #2 reset_n = 1'b1;
    tick(); chk(16'(rd_b)); chk(16'(proc_flags));

    // single-byte write with flags
    sb_push("r3_byp", 16'hA5);
    sb_push("r3_flags_byp", 16'h2);
    sb_push("r3_arr", 16'hA5);
    sb_push("r3_flags_arr", 16'h2);
    wr(4'd3, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h00, 4'h2);
    rd_b_sel = 4'd3; #1;
    chk(16'(rd_b)); chk(16'(proc_flags));
    tick(); chk(16'(rd_b)); chk(16'(proc_flags));

    // pair write to r14/r15 and read wrap past r15
    sb_push("pair_a_lo15_byp", 16'h12);
    sb_push("pair_a_hi_wrap_byp", 16'h00);
    sb_push("pair_r14_byp", 16'h34);
    sb_push("pair_flags_kept", 16'h2);
    sb_push("pair_a_lo15_arr", 16'h12);
    sb_push("pair_a_hi_wrap_arr", 16'h00);
    sb_push("pair_r14_arr", 16'h34);
    sb_push("pair_a_hi15", 16'h12);
    wr(4'd14, 1'b1, 1'b1, 1'b0, 8'h34, 8'h12, 4'h0);
    rd_a_sel = 4'd15; rd_b_sel = 4'd14; #1;
    chk(16'(rd_a_lo)); chk(16'(rd_a_hi)); chk(16'(rd_b)); chk(16'(proc_flags));
    tick(); chk(16'(rd_a_lo)); chk(16'(rd_a_hi)); chk(16'(rd_b));
    rd_a_sel = 4'd14; #1;
    chk(16'(rd_a_hi));

    // compare-only op updates flags only
    sb_push("cmp_r3_byp", 16'hA5);
    sb_push("cmp_flags_byp", 16'h8);
    sb_push("cmp_r3_arr", 16'hA5);
    sb_push("cmp_flags_arr", 16'h8);
    wr(4'd3, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 4'h8);
    rd_b_sel = 4'd3; #1;
    chk(16'(rd_b)); chk(16'(proc_flags));
    tick(); chk(16'(rd_b)); chk(16'(proc_flags));

    // stalled write is held off until hold drops
    sb_push("hold_ready", 16'h0);
    sb_push("hold_r7", 16'h0);
    sb_push("rel_r7_byp", 16'h99);
    sb_push("rel_r7_arr", 16'h99);
    drive_wb(4'd7, 1'b0, 1'b1, 1'b0, 8'h99, 8'h00, 4'h0);
    hold = 1'b1; rd_b_sel = 4'd7; #1;
    chk(16'(wb_ready));
    tick(); tick(); chk(16'(rd_b));
    hold = 1'b0;
    tick(); wb_valid = 1'b0; #1;
    chk(16'(rd_b));
    tick(); chk(16'(rd_b));

    // reserve and clear of r7 on the same edge: reserve wins
    sb_push("rsv_win_busy", 16'h0080);
    sb_push("rsv_win_r7", 16'h11);
    sb_push("clr_busy", 16'h0000);
    sb_push("clr_r7", 16'h22);
    sb_push("clr_r7_arr", 16'h22);
    rsv_valid = 1'b1; rsv_idx = 4'd7;
    wr(4'd7, 1'b0, 1'b1, 1'b0, 8'h11, 8'h00, 4'h0);
    rsv_valid = 1'b0; #1;
    chk(busy); chk(16'(rd_b));
    wr(4'd7, 1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 4'h0);
    #1;
    chk(busy); chk(16'(rd_b));
    tick(); chk(16'(rd_b));

    // back-to-back writes to r4: newest pending value wins
    sb_push("b2b_first", 16'h01);
    sb_push("b2b_second", 16'h02);
    sb_push("b2b_arr", 16'h02);
    rd_b_sel = 4'd4;
    drive_wb(4'd4, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 4'h0);
    tick();
    drive_wb(4'd4, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 4'h0);
    #1;
    chk(16'(rd_b));
    tick(); wb_valid = 1'b0; #1;
    chk(16'(rd_b));
    tick(); chk(16'(rd_b));

    // reservation lands during hold; flags-only write leaves busy set
    sb_push("rsv_hold_busy", 16'h1000);
    sb_push("nodata_busy", 16'h1000);
    hold = 1'b1; rsv_valid = 1'b1; rsv_idx = 4'd12;
    tick();
    rsv_valid = 1'b0; hold = 1'b0; #1;
    chk(busy);
    wr(4'd12, 1'b0, 1'b0, 1'b1, 8'h77, 8'h00, 4'h3);
    #1;
    chk(busy);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d unchecked expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
